// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared state encoding and constants for the pipeline hazard controller
package pipeline_ctrl_pkg;
  typedef enum logic [1:0] {ST_RUN, ST_STALL, ST_MEM_WAIT} state_t;
  localparam logic [1:0] MEMTOREG_LOAD = 2'b01;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/raw_hazard_detect.sv
// raw_hazard_detect: compares ID source operands against EX/MEM destinations
module raw_hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [4:0] rs1_addr_id,
  input  logic [4:0] rs2_addr_id,
  input  logic       rs1_used_id,
  input  logic       rs2_used_id,
  input  logic [4:0] rd_addr_ex,
  input  logic       reg_write_ex,
  input  logic [1:0] memto_reg_ex,
  input  logic [4:0] rd_addr_mem,
  input  logic       reg_write_mem,
  output logic       hit_ex,
  output logic       hit_ex_load,
  output logic       hit_mem
);
  assign hit_ex = reg_write_ex && rd_addr_ex != REG_ZERO &&
                  ((rs1_used_id && rs1_addr_id == rd_addr_ex) || (rs2_used_id && rs2_addr_id == rd_addr_ex));
  assign hit_ex_load = hit_ex && memto_reg_ex == MEMTOREG_LOAD;
  assign hit_mem = reg_write_mem && rd_addr_mem != REG_ZERO &&
                   ((rs1_used_id && rs1_addr_id == rd_addr_mem) || (rs2_used_id && rs2_addr_id == rd_addr_mem));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/freeze sequencer for the 5-stage pipeline
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int FORWARDING  = 1,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 7
) (
  input  logic       clk_IDEX,
  input  logic       rst_IDEX,
  input  logic [4:0] Rs1_addr_ID,
  input  logic [4:0] Rs2_addr_ID,
  input  logic       Rs1_used_ID,
  input  logic       Rs2_used_ID,
  input  logic [4:0] Rd_addr_EX,
  input  logic       RegWrite_EX,
  input  logic [1:0] MemtoReg_EX,
  input  logic [4:0] Rd_addr_MEM,
  input  logic       RegWrite_MEM,
  input  logic       branch_taken_EX,
  input  logic       dmem_req_MEM,
  input  logic       dmem_ack,
  output logic       pc_en,
  output logic       en_IFID,
  output logic       flush_IFID,
  output logic       en_IDEX,
  output logic       flush_IDEX,
  output logic       en_EXMEM,
  output logic       en_MEMWB,
  output logic       stall_active,
  output logic       mem_err
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  state_t state_q, state_d, ret_q, ret_d, eff_state;
  logic [CNT_W-1:0] cnt_q, cnt_d, ret_cnt_q, ret_cnt_d, eff_cnt;
  logic mem_err_q, mem_err_d;
  logic hit_ex, hit_ex_load, hit_mem, data_stall, in_wait, timeout, hold;

  raw_hazard_detect u_raw (
    .rs1_addr_id  (Rs1_addr_ID),
    .rs2_addr_id  (Rs2_addr_ID),
    .rs1_used_id  (Rs1_used_ID),
    .rs2_used_id  (Rs2_used_ID),
    .rd_addr_ex   (Rd_addr_EX),
    .reg_write_ex (RegWrite_EX),
    .memto_reg_ex (MemtoReg_EX),
    .rd_addr_mem  (Rd_addr_MEM),
    .reg_write_mem(RegWrite_MEM),
    .hit_ex       (hit_ex),
    .hit_ex_load  (hit_ex_load),
    .hit_mem      (hit_mem)
  );

  // Next state and enables; a release cycle out of MEM_WAIT behaves as a normal cycle of the saved state
  always_comb begin
    in_wait = state_q == ST_MEM_WAIT;
    timeout = in_wait && MEM_TIMEOUT != 0 && cnt_q == CNT_LAST && !dmem_ack;
    hold = in_wait ? !(dmem_ack || timeout) : (dmem_req_MEM && !dmem_ack);
    eff_state = in_wait ? ret_q : state_q;
    eff_cnt = in_wait ? ret_cnt_q : cnt_q;
    data_stall = FORWARDING != 0 ? hit_ex_load : (hit_ex || hit_mem);
    pc_en = 1'b1;
    en_IFID = 1'b1;
    flush_IFID = 1'b0;
    en_IDEX = 1'b1;
    flush_IDEX = 1'b0;
    en_EXMEM = 1'b1;
    en_MEMWB = 1'b1;
    state_d = ST_RUN;
    cnt_d = '0;
    ret_d = ret_q;
    ret_cnt_d = ret_cnt_q;
    mem_err_d = mem_err_q || timeout;
    if (hold) begin
      pc_en = 1'b0;
      en_IFID = 1'b0;
      en_IDEX = 1'b0;
      en_EXMEM = 1'b0;
      en_MEMWB = 1'b0;
      state_d = ST_MEM_WAIT;
      cnt_d = in_wait ? cnt_q + 1'b1 : '0;
      ret_d = in_wait ? ret_q : state_q;
      ret_cnt_d = in_wait ? ret_cnt_q : cnt_q;
    end else if (eff_state == ST_STALL) begin
      pc_en = 1'b0;
      en_IFID = 1'b0;
      flush_IDEX = 1'b1;
      state_d = eff_cnt > CNT_W'(1) ? ST_STALL : ST_RUN;
      cnt_d = eff_cnt - 1'b1;
    end else if (branch_taken_EX) begin
      flush_IFID = 1'b1;
      flush_IDEX = 1'b1;
    end else if (data_stall) begin
      pc_en = 1'b0;
      en_IFID = 1'b0;
      flush_IDEX = 1'b1;
      state_d = (FORWARDING == 0 && hit_ex) ? ST_STALL : ST_RUN;
      cnt_d = (FORWARDING == 0 && hit_ex) ? CNT_W'(1) : '0;
    end
    stall_active = state_q != ST_RUN || !pc_en || flush_IFID || flush_IDEX;
  end

  assign mem_err = mem_err_q;

  // State, counter, saved context and sticky error registers
  always_ff @(posedge clk_IDEX or posedge rst_IDEX) begin
    if (rst_IDEX) begin
      state_q <= ST_RUN;
      ret_q <= ST_RUN;
      cnt_q <= '0;
      ret_cnt_q <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q <= ret_d;
      cnt_q <= cnt_d;
      ret_cnt_q <= ret_cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  a_no_branch_in_stall: assert property (@(posedge clk_IDEX) disable iff (rst_IDEX)
    state_q == ST_STALL |-> !branch_taken_EX);
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and randomized checks of both forwarding configurations
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] rs1, rs2, rd_ex, rd_mem;
  logic u1, u2, rw_ex, rw_mem, br, req, ack;
  logic [1:0] m2r;
  logic [8:0] o_fw, o_nf;
  int checks = 0;
  int failures = 0;
  int stall_left[2], waited[2], saved_left[2];
  bit waiting[2], err[2];
  // {pc_en, en_IFID, flush_IFID, en_IDEX, flush_IDEX, en_EXMEM, en_MEMWB, stall_active, mem_err}
  localparam logic [8:0] RUN_OK   = 9'b110101100;
  localparam logic [8:0] RUN_ERR  = 9'b110101101;
  localparam logic [8:0] STALL_O  = 9'b000111110;
  localparam logic [8:0] FLUSH_O  = 9'b111111110;
  localparam logic [8:0] FREEZE_O = 9'b000000010;
  localparam logic [8:0] REL_O    = 9'b110101110;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.FORWARDING(1), .MEM_TIMEOUT(8), .CNT_W(7)) dut_fw (
    .clk_IDEX(clk), .rst_IDEX(rst), .Rs1_addr_ID(rs1), .Rs2_addr_ID(rs2),
    .Rs1_used_ID(u1), .Rs2_used_ID(u2), .Rd_addr_EX(rd_ex), .RegWrite_EX(rw_ex),
    .MemtoReg_EX(m2r), .Rd_addr_MEM(rd_mem), .RegWrite_MEM(rw_mem),
    .branch_taken_EX(br), .dmem_req_MEM(req), .dmem_ack(ack),
    .pc_en(o_fw[8]), .en_IFID(o_fw[7]), .flush_IFID(o_fw[6]), .en_IDEX(o_fw[5]),
    .flush_IDEX(o_fw[4]), .en_EXMEM(o_fw[3]), .en_MEMWB(o_fw[2]),
    .stall_active(o_fw[1]), .mem_err(o_fw[0]));

  pipeline_hazard_ctrl #(.FORWARDING(0), .MEM_TIMEOUT(64), .CNT_W(7)) dut_nf (
    .clk_IDEX(clk), .rst_IDEX(rst), .Rs1_addr_ID(rs1), .Rs2_addr_ID(rs2),
    .Rs1_used_ID(u1), .Rs2_used_ID(u2), .Rd_addr_EX(rd_ex), .RegWrite_EX(rw_ex),
    .MemtoReg_EX(m2r), .Rd_addr_MEM(rd_mem), .RegWrite_MEM(rw_mem),
    .branch_taken_EX(br), .dmem_req_MEM(req), .dmem_ack(ack),
    .pc_en(o_nf[8]), .en_IFID(o_nf[7]), .flush_IFID(o_nf[6]), .en_IDEX(o_nf[5]),
    .flush_IDEX(o_nf[4]), .en_EXMEM(o_nf[3]), .en_MEMWB(o_nf[2]),
    .stall_active(o_nf[1]), .mem_err(o_nf[0]));

  // Reference: i=0 forwarding/timeout 8, i=1 no forwarding/timeout 64; tracks remaining stall cycles and memory wait length
  function automatic logic [8:0] model(input int i);
    int to, left;
    bit fw, rel, hold, was, e, exm, mm, st;
    to = i == 0 ? 8 : 64;
    fw = i == 0;
    e = err[i];
    left = waiting[i] ? saved_left[i] : stall_left[i];
    rel = waiting[i] && (ack || waited[i] == to - 1);
    hold = waiting[i] ? !rel : (req && !ack);
    if (waiting[i] && !ack && waited[i] == to - 1) err[i] = 1'b1;
    if (hold) begin
      if (waiting[i]) waited[i]++;
      else begin
        saved_left[i] = stall_left[i];
        waited[i] = 0;
        waiting[i] = 1'b1;
      end
      return {7'b0, 1'b1, e};
    end
    was = waiting[i];
    waiting[i] = 1'b0;
    stall_left[i] = 0;
    if (left > 0) begin
      stall_left[i] = left - 1;
      return {8'b00011111, e};
    end
    if (br) return {8'hFF, e};
    exm = rw_ex && rd_ex != 0 && ((u1 && rs1 == rd_ex) || (u2 && rs2 == rd_ex));
    mm = rw_mem && rd_mem != 0 && ((u1 && rs1 == rd_mem) || (u2 && rs2 == rd_mem));
    st = fw ? (exm && m2r == 2'b01) : (exm || mm);
    if (!fw && exm) stall_left[i] = 1;
    return {!st, !st, 1'b0, 1'b1, st, 1'b1, 1'b1, st || was, e};
  endfunction

  task automatic clear_in;
    rs1 = 0; rs2 = 0; rd_ex = 0; rd_mem = 0; m2r = 0;
    u1 = 0; u2 = 0; rw_ex = 0; rw_mem = 0; br = 0; req = 0; ack = 0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    clear_in();
    for (int i = 0; i < 2; i++) begin
      stall_left[i] = 0; waited[i] = 0; saved_left[i] = 0; waiting[i] = 0; err[i] = 0;
    end
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    clear_in();
    rst = 1'b1;
    #1;
    checks++; if (o_fw !== RUN_OK) begin failures++; $display("FAIL reset_fw got=%b exp=%b", o_fw, RUN_OK); end
    checks++; if (o_nf !== RUN_OK) begin failures++; $display("FAIL reset_nf got=%b exp=%b", o_nf, RUN_OK); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_load_use;
    do_reset();
    rd_ex = 5; rw_ex = 1; m2r = 2'b01; rs1 = 5; u1 = 1;
    #1;
    checks++; if (o_fw !== STALL_O) begin failures++; $display("FAIL load_use_stall got=%b exp=%b", o_fw, STALL_O); end
    @(negedge clk);
    rw_ex = 0; rd_ex = 0; rd_mem = 5; rw_mem = 1;
    #1;
    checks++; if (o_fw !== RUN_OK) begin failures++; $display("FAIL load_use_resume got=%b exp=%b", o_fw, RUN_OK); end
    @(negedge clk);
  endtask

  task automatic test_rd_zero;
    do_reset();
    rd_ex = 0; rw_ex = 1; m2r = 2'b01; rs1 = 0; u1 = 1;
    for (int n = 0; n < 2; n++) begin
      #1;
      checks++; if (o_fw !== RUN_OK) begin failures++; $display("FAIL rd_zero_fw cyc=%0d got=%b exp=%b", n, o_fw, RUN_OK); end
      checks++; if (o_nf !== RUN_OK) begin failures++; $display("FAIL rd_zero_nf cyc=%0d got=%b exp=%b", n, o_nf, RUN_OK); end
      @(negedge clk);
    end
  endtask

  task automatic test_raw_no_fwd;
    do_reset();
    rd_ex = 7; rw_ex = 1; m2r = 2'b00; rs2 = 7; u2 = 1;
    #1;
    checks++; if (o_nf !== STALL_O) begin failures++; $display("FAIL raw_ex_c1 got=%b exp=%b", o_nf, STALL_O); end
    checks++; if (o_fw !== RUN_OK) begin failures++; $display("FAIL raw_alu_fw got=%b exp=%b", o_fw, RUN_OK); end
    @(negedge clk);
    rw_ex = 0; rd_ex = 0; rd_mem = 7; rw_mem = 1;
    #1;
    checks++; if (o_nf !== STALL_O) begin failures++; $display("FAIL raw_ex_c2 got=%b exp=%b", o_nf, STALL_O); end
    @(negedge clk);
    rw_mem = 0; rd_mem = 0;
    #1;
    checks++; if (o_nf !== RUN_OK) begin failures++; $display("FAIL raw_ex_c3 got=%b exp=%b", o_nf, RUN_OK); end
    @(negedge clk);
    rd_mem = 3; rw_mem = 1; rs1 = 3; u1 = 1;
    #1;
    checks++; if (o_nf !== STALL_O) begin failures++; $display("FAIL raw_mem_c1 got=%b exp=%b", o_nf, STALL_O); end
    checks++; if (o_fw !== RUN_OK) begin failures++; $display("FAIL raw_mem_fw got=%b exp=%b", o_fw, RUN_OK); end
    @(negedge clk);
    clear_in();
    #1;
    checks++; if (o_nf !== RUN_OK) begin failures++; $display("FAIL raw_mem_c2 got=%b exp=%b", o_nf, RUN_OK); end
    @(negedge clk);
  endtask

  task automatic test_branch_load;
    do_reset();
    rd_ex = 5; rw_ex = 1; m2r = 2'b01; rs1 = 5; u1 = 1; br = 1;
    #1;
    checks++; if (o_fw !== FLUSH_O) begin failures++; $display("FAIL branch_fw got=%b exp=%b", o_fw, FLUSH_O); end
    checks++; if (o_nf !== FLUSH_O) begin failures++; $display("FAIL branch_nf got=%b exp=%b", o_nf, FLUSH_O); end
    @(negedge clk);
    clear_in();
    #1;
    checks++; if (o_fw !== RUN_OK) begin failures++; $display("FAIL branch_after_fw got=%b exp=%b", o_fw, RUN_OK); end
    checks++; if (o_nf !== RUN_OK) begin failures++; $display("FAIL branch_after_nf got=%b exp=%b", o_nf, RUN_OK); end
    @(negedge clk);
  endtask

  task automatic test_mem_wait;
    do_reset();
    req = 1;
    for (int n = 0; n < 4; n++) begin
      ack = n == 3;
      #1;
      checks++; if (o_fw !== (n == 3 ? REL_O : FREEZE_O)) begin failures++; $display("FAIL mem_wait_fw cyc=%0d got=%b", n, o_fw); end
      checks++; if (o_nf !== (n == 3 ? REL_O : FREEZE_O)) begin failures++; $display("FAIL mem_wait_nf cyc=%0d got=%b", n, o_nf); end
      @(negedge clk);
    end
    req = 0; ack = 0;
    #1;
    checks++; if (o_fw !== RUN_OK) begin failures++; $display("FAIL mem_wait_after got=%b exp=%b", o_fw, RUN_OK); end
    @(negedge clk);
    req = 1; ack = 1;
    #1;
    checks++; if (o_fw !== RUN_OK) begin failures++; $display("FAIL single_ack got=%b exp=%b", o_fw, RUN_OK); end
    @(negedge clk);
    req = 0; ack = 0;
    #1;
    checks++; if (o_fw !== RUN_OK) begin failures++; $display("FAIL single_ack_next got=%b exp=%b", o_fw, RUN_OK); end
    @(negedge clk);
  endtask

  task automatic test_timeout_reset;
    do_reset();
    req = 1;
    for (int n = 0; n < 9; n++) begin
      #1;
      checks++; if (o_fw !== (n == 8 ? REL_O : FREEZE_O)) begin failures++; $display("FAIL timeout_fw cyc=%0d got=%b", n, o_fw); end
      @(negedge clk);
    end
    req = 0; ack = 1;
    #1;
    checks++; if (o_fw !== RUN_ERR) begin failures++; $display("FAIL timeout_err got=%b exp=%b", o_fw, RUN_ERR); end
    checks++; if (o_nf !== REL_O) begin failures++; $display("FAIL timeout_nf_rel got=%b exp=%b", o_nf, REL_O); end
    @(negedge clk);
    ack = 0;
    rd_ex = 7; rw_ex = 1; rs2 = 7; u2 = 1;
    #1;
    checks++; if (o_nf !== STALL_O) begin failures++; $display("FAIL pre_reset_stall got=%b exp=%b", o_nf, STALL_O); end
    checks++; if (o_fw !== RUN_ERR) begin failures++; $display("FAIL err_sticky got=%b exp=%b", o_fw, RUN_ERR); end
    @(negedge clk);
    clear_in();
    #1;
    checks++; if (o_nf !== STALL_O) begin failures++; $display("FAIL in_stall got=%b exp=%b", o_nf, STALL_O); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (o_nf !== RUN_OK) begin failures++; $display("FAIL async_reset_nf got=%b exp=%b", o_nf, RUN_OK); end
    checks++; if (o_fw !== RUN_OK) begin failures++; $display("FAIL async_reset_err got=%b exp=%b", o_fw, RUN_OK); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random;
    logic [8:0] e0, e1;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
      rd_ex = 5'($urandom_range(0, 3)); rd_mem = 5'($urandom_range(0, 3));
      u1 = 1'($urandom); u2 = 1'($urandom); rw_ex = 1'($urandom); rw_mem = 1'($urandom);
      m2r = 2'($urandom);
      req = $urandom_range(0, 3) == 0;
      ack = $urandom_range(0, 5) == 0;
      br = $urandom_range(0, 4) == 0 && (waiting[1] ? saved_left[1] : stall_left[1]) == 0;
      #1;
      e0 = model(0);
      e1 = model(1);
      checks++; if (o_fw !== e0) begin failures++; $display("FAIL random_fw cyc=%0d got=%b exp=%b", n, o_fw, e0); end
      checks++; if (o_nf !== e1) begin failures++; $display("FAIL random_nf cyc=%0d got=%b exp=%b", n, o_nf, e1); end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_rd_zero();
    test_raw_no_fwd();
    test_branch_load();
    test_mem_wait();
    test_timeout_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
